// File: rtl/fmap_result_packer.sv
// fmap_result_packer
// Requantizes pooled 32-bit conv results to signed 16 bits.
// Pipeline: stage Q register, then a first-word-fall-through FIFO driving a
// valid/ready stream with a per-frame last marker.
// The pooler cannot be stalled, so the block raises sticky flags instead:
// dropped samples, saturation, and short frames.
// Optional feature: define OUTQ_ROUND_EN for round-half-up before the shift.
// With it undefined, q is a plain arithmetic shift (truncation) and no adder
// is built.
module fmap_result_packer #(
  parameter int N     = 10,
  parameter int K     = 3,
  parameter int P     = 2,
  parameter int SHIFT = 8,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        global_rst,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  input  logic        end_in,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        frame_done,
  output logic        overflow,
  output logic        sat_flag,
  output logic        short_frame
);

  localparam int OUT_SIDE = (N - K + 1) / P;
  localparam int OUT_CNT  = OUT_SIDE * OUT_SIDE;
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW       = $clog2(OUT_CNT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(OUT_CNT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  // True when the shifted value lies outside the 16-bit signed range.
  function automatic logic is_clip(input logic signed [32:0] x);
    return (x > 33'sd32767) || (x < -33'sd32768);
  endfunction

  // Clamps the shifted value to the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [32:0] x);
    if (x > 33'sd32767)
      return 16'sh7FFF;
    else if (x < -33'sd32768)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction

  logic signed [32:0] w_ext;
  logic signed [32:0] w_pre;
  logic signed [32:0] w_shr;

  // Sign-extend to 33 bits so the rounding add can never wrap.
  assign w_ext = {data_in[31], data_in};

`ifdef OUTQ_ROUND_EN
  generate
    if (SHIFT > 0) begin : g_round
      assign w_pre = w_ext + (33'sd1 <<< (SHIFT - 1));
    end else begin : g_noround
      assign w_pre = w_ext;
    end
  endgenerate
`else
  assign w_pre = w_ext;
`endif

  assign w_shr = w_pre >>> SHIFT;

  // ---- stage Q (p0) ----
  logic               r_vld_p0;
  logic               r_end_p0;
  logic signed [15:0] r_q_p0;
  logic               r_sat;

  // Stage Q control: the valid bit, the end pulse delayed to align with
  // stage Q, and the sticky saturation flag.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      r_vld_p0 <= 1'b0;
      r_end_p0 <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_vld_p0 <= valid_in;
      r_end_p0 <= end_in;
      if (valid_in && is_clip(w_shr))
        r_sat <= 1'b1;
    end
  end

  // Stage Q data register; its contents only matter while r_vld_p0 is set.
  always_ff @(posedge clk) begin
    if (valid_in)
      r_q_p0 <= sat16(w_shr);
  end

  // ---- frame counter / FIFO write (p1) ----
  logic [CW-1:0] r_fcnt;
  logic          r_short;
  logic          w_wrap;
  logic          w_short;

  assign w_wrap  = r_vld_p0 && (r_fcnt == LAST_IDX);
  assign w_short = r_end_p0 && (r_fcnt != '0) && !w_wrap;

  // The frame counter advances on every stage-Q word, including dropped
  // words, so m_last stays aligned. A premature end_in restarts the frame.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      r_fcnt  <= '0;
      r_short <= 1'b0;
    end else if (w_short) begin
      r_fcnt  <= '0;
      r_short <= 1'b1;
    end else if (r_vld_p0) begin
      r_fcnt <= w_wrap ? '0 : r_fcnt + CW'(1);
    end
  end

  logic [16:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_occ;
  logic          r_ovf;
  logic          r_fd;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [16:0]   w_head;

  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == FULL_CNT);
  assign w_pop   = !w_empty && m_ready;
  // A push into a full FIFO is still legal when a pop frees a slot in the same cycle.
  assign w_push  = r_vld_p0 && (!w_full || w_pop);
  assign w_drop  = r_vld_p0 && w_full && !w_pop;
  assign w_head  = r_mem[r_rd];

  // FIFO pointers, occupancy, overflow flag, and the frame_done pulse.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_occ <= '0;
      r_ovf <= 1'b0;
      r_fd  <= 1'b0;
    end else begin
      if (w_push)
        r_wr <= r_wr + AW'(1);
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (AW + 1)'(1);
        2'b01:   r_occ <= r_occ - (AW + 1)'(1);
        default: r_occ <= r_occ;
      endcase
      if (w_drop)
        r_ovf <= 1'b1;
      r_fd <= w_pop && w_head[16];
    end
  end

  // FIFO storage of {last, q}; the storage needs no reset because occupancy gates it.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= {w_wrap, r_q_p0};
  end

  // ---- output (first-word-fall-through) ----
  assign m_valid     = !w_empty;
  assign m_data      = w_empty ? 16'h0000 : w_head[15:0];
  assign m_last      = !w_empty && w_head[16];
  assign frame_done  = r_fd;
  assign overflow    = r_ovf;
  assign sat_flag    = r_sat;
  assign short_frame = r_short;

endmodule
